ycr1_mem_arb: RTL and testbench

Two-to-one arbiter sharing one downstream memory port between the core instruction fetch (IMEM) and data (DMEM) requesters, using the standard req/req_ack/resp handshake. It sits between the core memory interfaces and the shared TCM/bus bridge. It grants one request per cycle and tracks up to OUTSTD outstanding transactions in an ordered owner FIFO, so each in-order response returns to the requester that issued it.

---
 rtl/ycr1_mem_arb.sv | 214 +++++++++++++++++++++
 tb/tb_ycr1_mem_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycr1_mem_arb.sv
// ----------------------------------------------------------------------------
// ycr1_mem_arb
//   Two-to-one arbiter that shares one downstream memory port between the
//   core instruction-fetch (IMEM) and data (DMEM) requesters. One request is
//   granted per cycle. An ordered owner FIFO holds up to OUTSTD
//   accepted-but-unanswered transactions, so each in-order response goes back
//   to the requester that issued it.
//
//   Compile-time option:
//     YCR1_MEM_ARB_RR_EN  defined   -> round-robin arbitration
//                         undefined -> fixed priority, DMEM over IMEM
//
//   Ports:
//     clk_i, rst_i              clock, asynchronous active-high reset
//     imem_*_i / imem_*_o       IMEM requester (read only)
//     dmem_*_i / dmem_*_o       DMEM requester (read/write, byte/half/word)
//     mem_*_o  / mem_*_i        shared downstream memory port
//     arb_err_o                 one-cycle pulse after a response arrives
//                               while no transaction is pending
// ----------------------------------------------------------------------------
module ycr1_mem_arb #(
   parameter int unsigned AW     = 32,
   parameter int unsigned DW     = 32,
   parameter int unsigned OUTSTD = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   // IMEM requester
   input  logic          imem_req_i,
   input  logic          imem_cmd_i,
   input  logic [AW-1:0] imem_addr_i,
   output logic          imem_req_ack_o,
   output logic [DW-1:0] imem_rdata_o,
   output logic [1:0]    imem_resp_o,
   // DMEM requester
   input  logic          dmem_req_i,
   input  logic          dmem_cmd_i,
   input  logic [1:0]    dmem_width_i,
   input  logic [AW-1:0] dmem_addr_i,
   input  logic [DW-1:0] dmem_wdata_i,
   output logic          dmem_req_ack_o,
   output logic [DW-1:0] dmem_rdata_o,
   output logic [1:0]    dmem_resp_o,
   // Downstream memory port
   output logic          mem_req_o,
   output logic          mem_cmd_o,
   output logic [1:0]    mem_width_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic          mem_req_ack_i,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic [1:0]    mem_resp_i,
   // Status
   output logic          arb_err_o
);

   localparam int unsigned CW = $clog2(OUTSTD + 1);
   localparam int unsigned PW = (OUTSTD > 1) ? $clog2(OUTSTD) : 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTD);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTD - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   typedef enum logic {
      OWN_IMEM = 1'b0,
      OWN_DMEM = 1'b1
   } owner_e;

   owner_e          fifo_q [OUTSTD];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic            lock_q;
   owner_e          lock_id_q;
   logic            arb_err_q;

   owner_e          sel;
   owner_e          grant;
   owner_e          head;
   logic            full, empty;
   logic            gnt_req;
   logic            accept;
   logic            pop;
   logic            resp_vld;

   assign full     = (cnt_q == CNT_FULL);
   assign empty    = (cnt_q == '0);
   assign resp_vld = |mem_resp_i;
   assign head     = fifo_q[rd_ptr_q];

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
`ifdef YCR1_MEM_ARB_RR_EN
   owner_e pref_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pref_q <= OWN_DMEM;
      end else if (accept) begin
         pref_q <= (grant == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
      end
   end

   always_comb begin
      sel = OWN_DMEM;
      if (pref_q == OWN_DMEM) begin
         sel = (imem_req_i & ~dmem_req_i) ? OWN_IMEM : OWN_DMEM;
      end else begin
         sel = (dmem_req_i & ~imem_req_i) ? OWN_DMEM : OWN_IMEM;
      end
   end
`else
   always_comb begin
      sel = (imem_req_i & ~dmem_req_i) ? OWN_IMEM : OWN_DMEM;
   end
`endif

   // A stalled request keeps its grant so the payload stays stable.
   assign grant   = lock_q ? lock_id_q : sel;
   assign gnt_req = (grant == OWN_DMEM) ? dmem_req_i : imem_req_i;

   // Full blocks the request even when a pop happens in the same cycle,
   // avoiding a combinational resp-to-ack path. Reset forces idle outputs.
   assign mem_req_o      = gnt_req & ~full & ~rst_i;
   assign accept         = mem_req_o & mem_req_ack_i;
   assign imem_req_ack_o = accept & (grant == OWN_IMEM);
   assign dmem_req_ack_o = accept & (grant == OWN_DMEM);

   always_comb begin
      if (grant == OWN_DMEM) begin
         mem_cmd_o   = dmem_cmd_i;
         mem_width_o = dmem_width_i;
         mem_addr_o  = dmem_addr_i;
         mem_wdata_o = dmem_wdata_i;
      end else begin
         mem_cmd_o   = imem_cmd_i;
         mem_width_o = 2'b10;
         mem_addr_o  = imem_addr_i;
         mem_wdata_o = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q    <= 1'b0;
         lock_id_q <= OWN_DMEM;
      end else if (accept) begin
         lock_q    <= 1'b0;
      end else if (mem_req_o) begin
         lock_q    <= 1'b1;
         lock_id_q <= grant;
      end
   end

   // ---------------------------------------------------------------------
   // Owner FIFO
   // ---------------------------------------------------------------------
   assign pop = resp_vld & ~empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < OUTSTD; i++) begin
            fifo_q[i] <= OWN_DMEM;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (accept) begin
            fifo_q[wr_ptr_q] <= grant;
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_ONE;
         end
         case ({accept, pop})
            2'b10:   cnt_q <= cnt_q + CNT_ONE;
            2'b01:   cnt_q <= cnt_q - CNT_ONE;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Response routing
   // ---------------------------------------------------------------------
   always_comb begin
      imem_resp_o  = 2'b00;
      imem_rdata_o = '0;
      dmem_resp_o  = 2'b00;
      dmem_rdata_o = '0;
      if (!empty) begin
         if (head == OWN_IMEM) begin
            imem_resp_o  = mem_resp_i;
            imem_rdata_o = mem_rdata_i;
         end else begin
            dmem_resp_o  = mem_resp_i;
            dmem_rdata_o = mem_rdata_i;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         arb_err_q <= 1'b0;
      end else begin
         arb_err_q <= resp_vld & empty;
      end
   end

   assign arb_err_o = arb_err_q;

endmodule

// File: tb/tb_ycr1_mem_arb.sv
// ----------------------------------------------------------------------------
// tb_ycr1_mem_arb
//   Directed self-checking bench for ycr1_mem_arb (OUTSTD=2). Inputs change on
//   the falling clock edge; outputs are sampled 1ns later, well away from the
//   rising edge. Expected grants follow YCR1_MEM_ARB_RR_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_ycr1_mem_arb;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_i, imem_cmd_i;
   logic [31:0] imem_addr_i;
   logic        imem_req_ack_o;
   logic [31:0] imem_rdata_o;
   logic [1:0]  imem_resp_o;
   logic        dmem_req_i, dmem_cmd_i;
   logic [1:0]  dmem_width_i;
   logic [31:0] dmem_addr_i, dmem_wdata_i;
   logic        dmem_req_ack_o;
   logic [31:0] dmem_rdata_o;
   logic [1:0]  dmem_resp_o;
   logic        mem_req_o, mem_cmd_o;
   logic [1:0]  mem_width_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic        mem_req_ack_i;
   logic [31:0] mem_rdata_i;
   logic [1:0]  mem_resp_i;
   logic        arb_err_o;

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   ycr1_mem_arb #(.AW(32), .DW(32), .OUTSTD(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .imem_req_i(imem_req_i), .imem_cmd_i(imem_cmd_i), .imem_addr_i(imem_addr_i),
      .imem_req_ack_o(imem_req_ack_o), .imem_rdata_o(imem_rdata_o), .imem_resp_o(imem_resp_o),
      .dmem_req_i(dmem_req_i), .dmem_cmd_i(dmem_cmd_i), .dmem_width_i(dmem_width_i),
      .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
      .dmem_req_ack_o(dmem_req_ack_o), .dmem_rdata_o(dmem_rdata_o), .dmem_resp_o(dmem_resp_o),
      .mem_req_o(mem_req_o), .mem_cmd_o(mem_cmd_o), .mem_width_o(mem_width_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_req_ack_i(mem_req_ack_i), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
      .arb_err_o(arb_err_o)
   );

   task automatic test_reset();
      rst_i = 1'b1;
      imem_req_i = 1'b1; imem_cmd_i = 1'b0; imem_addr_i = 32'h0;
      dmem_req_i = 1'b1; dmem_cmd_i = 1'b0; dmem_width_i = 2'b10;
      dmem_addr_i = 32'h0; dmem_wdata_i = 32'h0;
      mem_req_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; mem_resp_i = 2'b01;
      repeat (2) @(negedge clk_i);
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req_o); end
      checks++; if (imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL reset_imem_ack got %b exp 0", imem_req_ack_o); end
      checks++; if (dmem_req_ack_o !== 1'b0) begin errors++; $display("FAIL reset_dmem_ack got %b exp 0", dmem_req_ack_o); end
      checks++; if (imem_resp_o !== 2'b00) begin errors++; $display("FAIL reset_imem_resp got %b exp 00", imem_resp_o); end
      checks++; if (dmem_resp_o !== 2'b00) begin errors++; $display("FAIL reset_dmem_resp got %b exp 00", dmem_resp_o); end
      checks++; if (imem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_imem_rdata got %h exp 0", imem_rdata_o); end
      checks++; if (dmem_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_dmem_rdata got %h exp 0", dmem_rdata_o); end
      checks++; if (arb_err_o !== 1'b0) begin errors++; $display("FAIL reset_arb_err got %b exp 0", arb_err_o); end
      @(negedge clk_i);
      rst_i = 1'b0; imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_resp_i = 2'b00; mem_req_ack_i = 1'b0;
   endtask

   task automatic test_single_imem();
      @(negedge clk_i);
      imem_req_i = 1'b1; imem_addr_i = 32'h0001_0000; mem_req_ack_i = 1'b1;
      #1;
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL single_mem_req got %b exp 1", mem_req_o); end
      checks++; if (imem_req_ack_o !== 1'b1) begin errors++; $display("FAIL single_imem_ack got %b exp 1", imem_req_ack_o); end
      checks++; if (dmem_req_ack_o !== 1'b0) begin errors++; $display("FAIL single_dmem_ack got %b exp 0", dmem_req_ack_o); end
      checks++; if (mem_addr_o !== 32'h0001_0000) begin errors++; $display("FAIL single_addr got %h exp 00010000", mem_addr_o); end
      checks++; if (mem_width_o !== 2'b10) begin errors++; $display("FAIL single_width got %b exp 10", mem_width_o); end
      checks++; if (mem_wdata_o !== 32'h0) begin errors++; $display("FAIL single_wdata got %h exp 0", mem_wdata_o); end
      @(negedge clk_i);
      imem_req_i = 1'b0; mem_req_ack_i = 1'b0; mem_resp_i = 2'b01; mem_rdata_i = 32'hDEAD_BEEF;
      #1;
      checks++; if (imem_resp_o !== 2'b01) begin errors++; $display("FAIL single_imem_resp got %b exp 01", imem_resp_o); end
      checks++; if (imem_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_imem_rdata got %h exp deadbeef", imem_rdata_o); end
      checks++; if (dmem_resp_o !== 2'b00) begin errors++; $display("FAIL single_dmem_resp got %b exp 00", dmem_resp_o); end
      checks++; if (dmem_rdata_o !== 32'h0) begin errors++; $display("FAIL single_dmem_rdata got %h exp 0", dmem_rdata_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
      #1;
      checks++; if (imem_resp_o !== 2'b00) begin errors++; $display("FAIL single_imem_resp_end got %b exp 00", imem_resp_o); end
      checks++; if (arb_err_o !== 1'b0) begin errors++; $display("FAIL single_arb_err got %b exp 0", arb_err_o); end
   endtask

   task automatic test_both_requesting();
      logic [3:0] exp_d;   // bit k: grant k expected to be DMEM
`ifdef YCR1_MEM_ARB_RR_EN
      exp_d = 4'b0101;
`else
      exp_d = 4'b1111;
`endif
      imem_addr_i = 32'h0000_1000; dmem_addr_i = 32'h0000_2000;
      dmem_cmd_i = 1'b0; dmem_width_i = 2'b10;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk_i);
         imem_req_i = (k < 4); dmem_req_i = (k < 4); mem_req_ack_i = (k < 4);
         mem_resp_i = (k > 0) ? 2'b01 : 2'b00;
         mem_rdata_i = 32'h100 + k;
         #1;
         if (k < 4) begin
            checks++; if (dmem_req_ack_o !== exp_d[k]) begin errors++; $display("FAIL both_dmem_ack[%0d] got %b exp %b", k, dmem_req_ack_o, exp_d[k]); end
            checks++; if (imem_req_ack_o !== ~exp_d[k]) begin errors++; $display("FAIL both_imem_ack[%0d] got %b exp %b", k, imem_req_ack_o, ~exp_d[k]); end
            checks++; if (mem_addr_o !== (exp_d[k] ? 32'h2000 : 32'h1000)) begin errors++; $display("FAIL both_addr[%0d] got %h", k, mem_addr_o); end
         end
         if (k > 0) begin
            checks++; if (dmem_resp_o !== (exp_d[k-1] ? 2'b01 : 2'b00)) begin errors++; $display("FAIL both_dmem_resp[%0d] got %b exp %b", k, dmem_resp_o, exp_d[k-1] ? 2'b01 : 2'b00); end
            checks++; if (imem_resp_o !== (exp_d[k-1] ? 2'b00 : 2'b01)) begin errors++; $display("FAIL both_imem_resp[%0d] got %b exp %b", k, imem_resp_o, exp_d[k-1] ? 2'b00 : 2'b01); end
            checks++; if ((exp_d[k-1] ? dmem_rdata_o : imem_rdata_o) !== 32'h100 + k) begin errors++; $display("FAIL both_rdata[%0d] got d=%h i=%h exp %h", k, dmem_rdata_o, imem_rdata_o, 32'h100 + k); end
         end
      end
      @(negedge clk_i);
      mem_resp_i = 2'b00; mem_req_ack_i = 1'b0;
   endtask

   task automatic test_lock_dmem_stall();
      dmem_req_i = 1'b1; dmem_cmd_i = 1'b1; dmem_width_i = 2'b00;
      dmem_addr_i = 32'h0000_3000; dmem_wdata_i = 32'h0000_00A5;
      imem_addr_i = 32'h0000_4000;
      for (int k = 0; k < 3; k++) begin
         imem_req_i = (k > 0);
         #1;
         checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL dstall_mem_req[%0d] got %b exp 1", k, mem_req_o); end
         checks++; if (dmem_req_ack_o !== 1'b0 || imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL dstall_acks[%0d] got d=%b i=%b exp 0 0", k, dmem_req_ack_o, imem_req_ack_o); end
         checks++; if (mem_addr_o !== 32'h3000 || mem_wdata_o !== 32'hA5) begin errors++; $display("FAIL dstall_payload[%0d] got %h/%h exp 3000/a5", k, mem_addr_o, mem_wdata_o); end
         checks++; if (mem_width_o !== 2'b00 || mem_cmd_o !== 1'b1) begin errors++; $display("FAIL dstall_wcmd[%0d] got %b/%b exp 00/1", k, mem_width_o, mem_cmd_o); end
         @(negedge clk_i);
      end
      mem_req_ack_i = 1'b1;
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1 || imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL dstall_accept got d=%b i=%b exp 1 0", dmem_req_ack_o, imem_req_ack_o); end
      @(negedge clk_i);
      dmem_req_i = 1'b0;
      #1;
      checks++; if (imem_req_ack_o !== 1'b1) begin errors++; $display("FAIL dstall_imem_next got %b exp 1", imem_req_ack_o); end
      checks++; if (mem_addr_o !== 32'h4000 || mem_width_o !== 2'b10 || mem_wdata_o !== 32'h0) begin errors++; $display("FAIL dstall_imem_payload got %h/%b/%h", mem_addr_o, mem_width_o, mem_wdata_o); end
      @(negedge clk_i);
      imem_req_i = 1'b0; mem_req_ack_i = 1'b0; mem_resp_i = 2'b01; mem_rdata_i = 32'h11;
      #1;
      checks++; if (dmem_resp_o !== 2'b01 || imem_resp_o !== 2'b00) begin errors++; $display("FAIL dstall_resp0 got d=%b i=%b exp 01 00", dmem_resp_o, imem_resp_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b10; mem_rdata_i = 32'h22;
      #1;
      checks++; if (imem_resp_o !== 2'b10 || imem_rdata_o !== 32'h22 || dmem_resp_o !== 2'b00) begin errors++; $display("FAIL dstall_resp1_err got i=%b/%h d=%b exp 10/22 00", imem_resp_o, imem_rdata_o, dmem_resp_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
   endtask

   task automatic test_lock_imem_stall();
      imem_req_i = 1'b1; imem_addr_i = 32'h0000_5000;
      dmem_cmd_i = 1'b0; dmem_width_i = 2'b10; dmem_addr_i = 32'h0000_6000;
      #1;
      checks++; if (mem_addr_o !== 32'h5000 || imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL istall_first got %h ack=%b exp 5000 0", mem_addr_o, imem_req_ack_o); end
      @(negedge clk_i);
      dmem_req_i = 1'b1;
      #1;
      checks++; if (mem_addr_o !== 32'h5000 || dmem_req_ack_o !== 1'b0) begin errors++; $display("FAIL istall_locked got %h dack=%b exp 5000 0", mem_addr_o, dmem_req_ack_o); end
      @(negedge clk_i);
      mem_req_ack_i = 1'b1;
      #1;
      checks++; if (imem_req_ack_o !== 1'b1 || dmem_req_ack_o !== 1'b0) begin errors++; $display("FAIL istall_accept got i=%b d=%b exp 1 0", imem_req_ack_o, dmem_req_ack_o); end
      @(negedge clk_i);
      imem_req_i = 1'b0;
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1 || mem_addr_o !== 32'h6000) begin errors++; $display("FAIL istall_dmem_next got %b/%h exp 1/6000", dmem_req_ack_o, mem_addr_o); end
      @(negedge clk_i);
      dmem_req_i = 1'b0; mem_req_ack_i = 1'b0; mem_resp_i = 2'b01; mem_rdata_i = 32'h33;
      #1;
      checks++; if (imem_resp_o !== 2'b01 || imem_rdata_o !== 32'h33) begin errors++; $display("FAIL istall_resp0 got %b/%h exp 01/33", imem_resp_o, imem_rdata_o); end
      @(negedge clk_i);
      mem_rdata_i = 32'h44;
      #1;
      checks++; if (dmem_resp_o !== 2'b01 || dmem_rdata_o !== 32'h44 || imem_resp_o !== 2'b00) begin errors++; $display("FAIL istall_resp1 got d=%b/%h i=%b", dmem_resp_o, dmem_rdata_o, imem_resp_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
   endtask

   task automatic test_full();
      dmem_req_i = 1'b1; mem_req_ack_i = 1'b1; dmem_addr_i = 32'h0000_7000;
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1) begin errors++; $display("FAIL full_acc0 got %b exp 1", dmem_req_ack_o); end
      @(negedge clk_i);
      dmem_addr_i = 32'h0000_7004;
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1) begin errors++; $display("FAIL full_acc1 got %b exp 1", dmem_req_ack_o); end
      @(negedge clk_i);
      imem_req_i = 1'b1;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL full_mem_req got %b exp 0", mem_req_o); end
      checks++; if (dmem_req_ack_o !== 1'b0 || imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL full_acks got d=%b i=%b exp 0 0", dmem_req_ack_o, imem_req_ack_o); end
      @(negedge clk_i);
      imem_req_i = 1'b0; mem_resp_i = 2'b01; mem_rdata_i = 32'h55;
      #1;
      checks++; if (dmem_resp_o !== 2'b01 || dmem_rdata_o !== 32'h55) begin errors++; $display("FAIL full_pop_resp got %b/%h exp 01/55", dmem_resp_o, dmem_rdata_o); end
      checks++; if (mem_req_o !== 1'b0 || dmem_req_ack_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle got req=%b ack=%b exp 0 0", mem_req_o, dmem_req_ack_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
      #1;
      checks++; if (mem_req_o !== 1'b1 || dmem_req_ack_o !== 1'b1) begin errors++; $display("FAIL full_next_cycle got req=%b ack=%b exp 1 1", mem_req_o, dmem_req_ack_o); end
      @(negedge clk_i);
      dmem_req_i = 1'b0; mem_req_ack_i = 1'b0; mem_resp_i = 2'b01; mem_rdata_i = 32'h66;
      #1;
      checks++; if (dmem_resp_o !== 2'b01 || dmem_rdata_o !== 32'h66) begin errors++; $display("FAIL full_drain0 got %b/%h exp 01/66", dmem_resp_o, dmem_rdata_o); end
      @(negedge clk_i);
      mem_rdata_i = 32'h77;
      #1;
      checks++; if (dmem_resp_o !== 2'b01 || dmem_rdata_o !== 32'h77) begin errors++; $display("FAIL full_drain1 got %b/%h exp 01/77", dmem_resp_o, dmem_rdata_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
      #1;
      checks++; if (arb_err_o !== 1'b0) begin errors++; $display("FAIL full_no_err got %b exp 0", arb_err_o); end
   endtask

   task automatic test_stray_resp();
      @(negedge clk_i);
      mem_resp_i = 2'b01; mem_rdata_i = 32'h99;
      #1;
      checks++; if (imem_resp_o !== 2'b00 || dmem_resp_o !== 2'b00) begin errors++; $display("FAIL stray_resp got i=%b d=%b exp 00 00", imem_resp_o, dmem_resp_o); end
      checks++; if (imem_rdata_o !== 32'h0 || dmem_rdata_o !== 32'h0) begin errors++; $display("FAIL stray_rdata got i=%h d=%h exp 0 0", imem_rdata_o, dmem_rdata_o); end
      checks++; if (arb_err_o !== 1'b0) begin errors++; $display("FAIL stray_err_early got %b exp 0", arb_err_o); end
      @(negedge clk_i);
      mem_resp_i = 2'b00;
      #1;
      checks++; if (arb_err_o !== 1'b1) begin errors++; $display("FAIL stray_err_pulse got %b exp 1", arb_err_o); end
      @(negedge clk_i);
      #1;
      checks++; if (arb_err_o !== 1'b0) begin errors++; $display("FAIL stray_err_end got %b exp 0", arb_err_o); end
   endtask

   task automatic test_reset_pending();
      logic [1:0] resp_seq;
      logic [4:0] err_exp;
      @(negedge clk_i);
      dmem_req_i = 1'b1; mem_req_ack_i = 1'b1; dmem_addr_i = 32'h0000_8000;
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1) begin errors++; $display("FAIL rstp_acc0 got %b exp 1", dmem_req_ack_o); end
      @(negedge clk_i);
      #1;
      checks++; if (dmem_req_ack_o !== 1'b1) begin errors++; $display("FAIL rstp_acc1 got %b exp 1", dmem_req_ack_o); end
      @(negedge clk_i);
      rst_i = 1'b1; imem_req_i = 1'b1; mem_resp_i = 2'b01; mem_rdata_i = 32'hAA;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++; if (mem_req_o !== 1'b0 || dmem_req_ack_o !== 1'b0 || imem_req_ack_o !== 1'b0) begin errors++; $display("FAIL rstp_req[%0d] got %b %b %b exp 0 0 0", k, mem_req_o, dmem_req_ack_o, imem_req_ack_o); end
         checks++; if (dmem_resp_o !== 2'b00 || imem_resp_o !== 2'b00 || dmem_rdata_o !== 32'h0 || arb_err_o !== 1'b0) begin errors++; $display("FAIL rstp_resp[%0d] got %b %b %h %b", k, dmem_resp_o, imem_resp_o, dmem_rdata_o, arb_err_o); end
         @(negedge clk_i);
      end
      rst_i = 1'b0; imem_req_i = 1'b0; dmem_req_i = 1'b0; mem_req_ack_i = 1'b0;
      // responses for the two discarded transactions, separated by a gap
      resp_seq = 2'b00;
      err_exp  = 5'b01010;
      for (int k = 0; k < 5; k++) begin
         mem_resp_i = (k == 0 || k == 2) ? 2'b01 : 2'b00;
         #1;
         checks++; if (dmem_resp_o !== resp_seq || imem_resp_o !== resp_seq) begin errors++; $display("FAIL rstp_drop[%0d] got d=%b i=%b exp 00", k, dmem_resp_o, imem_resp_o); end
         checks++; if (arb_err_o !== err_exp[k]) begin errors++; $display("FAIL rstp_err[%0d] got %b exp %b", k, arb_err_o, err_exp[k]); end
         @(negedge clk_i);
      end
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_imem();
      test_both_requesting();
      test_lock_dmem_stall();
      test_lock_imem_stall();
      test_full();
      test_stray_resp();
      test_reset_pending();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
